// File: rtl/div_iter_if.sv
// Start/ready divide handshake between the EX stage (master) and the
// iterative divider (slave). Carries the operands, the request and abort
// controls, and the packed {remainder, quotient} result.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider serving DIV/DIVU. Operates on
// magnitudes and applies the sign correction when the last step retires.
// One quotient bit per cycle; result and ready are fully registered.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     resetn,
  div_iter_if.slave bus
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH:0]       r_rem;      // partial remainder, one guard bit
  logic [WIDTH-1:0]     r_dividend; // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]     r_divisor;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_ready;

  logic                 w_go;
  logic                 w_sign1;
  logic                 w_sign2;
  logic [WIDTH+1:0]     w_trial;
  logic                 w_qbit;
  logic [WIDTH:0]       w_rem_next;
  logic [WIDTH-1:0]     w_quo_next;

  // Two's-complement negate when requested; used for magnitudes and sign fix-up.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign w_go    = bus.start_i & ~bus.annul_i;
  assign w_sign1 = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign w_sign2 = bus.signed_div_i & bus.opdata2_i[WIDTH-1];

  // One restoring step: shift in the next dividend bit, trial-subtract,
  // the borrow (top bit of the WIDTH+2 difference) decides the quotient bit.
  assign w_trial    = {r_rem, r_dividend[WIDTH-1]} - {2'b00, r_divisor};
  assign w_qbit     = ~w_trial[WIDTH+1];
  assign w_rem_next = w_qbit ? w_trial[WIDTH:0]
                             : {r_rem[WIDTH-1:0], r_dividend[WIDTH-1]};
  assign w_quo_next = {r_dividend[WIDTH-2:0], w_qbit};

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= FREE;
    else         r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FREE:    if (w_go) w_next_state = (bus.opdata2_i == '0) ? BYZERO : ON;
      BYZERO:  w_next_state = bus.annul_i ? FREE : END;
      ON: begin
        if (bus.annul_i)       w_next_state = FREE;
        else if (r_cnt == LAST) w_next_state = END;
      end
      END:     if (!bus.start_i) w_next_state = FREE;
      default: w_next_state = FREE;
    endcase
  end

  // Datapath: operand capture, iteration, and registered result/ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        FREE: begin
          r_result <= '0;
          r_ready  <= 1'b0;
          if (w_go && bus.opdata2_i != '0) begin
            r_dividend <= cond_neg(bus.opdata1_i, w_sign1);
            r_divisor  <= cond_neg(bus.opdata2_i, w_sign2);
            r_neg_q    <= w_sign1 ^ w_sign2;
            r_neg_r    <= w_sign1;
            r_rem      <= '0;
            r_cnt      <= '0;
          end
        end
        BYZERO: begin
          if (!bus.annul_i) begin
            r_result <= '0;
            r_ready  <= 1'b1;
          end
        end
        ON: begin
          if (!bus.annul_i) begin
            r_rem      <= w_rem_next;
            r_dividend <= w_quo_next;
            r_cnt      <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_result <= {cond_neg(w_rem_next[WIDTH-1:0], r_neg_r),
                           cond_neg(w_quo_next, r_neg_q)};
              r_ready  <= 1'b1;
            end
          end
        end
        END: begin
          if (!bus.start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_result <= '0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: scoreboard of expected results from a
// native-arithmetic reference model, popped when ready_o rises.
module tb_div_iter;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;
  logic [63:0] exp_q[$];

  div_iter_if #(.WIDTH(32)) bus ();

  div_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint da, dv, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      da = longint'($signed(a));
      dv = longint'($signed(b));
      q  = da / dv;
      r  = da % dv;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Issue one divide with start held, scramble operands after the start
  // edge, and wait (bounded) for ready_o. Leaves start_i high.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, output logic [63:0] e);
    int n;
    logic [63:0] head;
    e = model(s, a, b);
    exp_q.push_back(e);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~s;
      end
    end while (!bus.ready_o && n < 100);
    chk("latency", 64'(n), 64'(exp_lat));
    head = exp_q.pop_front();
    if (bus.ready_o) chk("result", bus.result_o, head);
    else             chk("ready_timeout", 64'(bus.ready_o), 64'd1);
  endtask

  task automatic drop_start();
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    chk("drop_ready", 64'(bus.ready_o), 64'd0);
    chk("drop_result", bus.result_o, 64'd0);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int hi;
    hi = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o) hi++;
    end
    chk(tag, 64'(hi), 64'd0);
  endtask

  initial begin
    logic [63:0] e;
    logic [31:0] ra, rb;
    n_checks = 0;
    n_fail   = 0;
    resetn           = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Unsigned 100/7, then hold start in END with changing operands and annul.
    run_div(1'b0, 32'd100, 32'd7, 33, e);
    chk("100_7_const", e, {32'd2, 32'd14});
    for (int i = 0; i < 5; i++) begin
      bus.opdata1_i = $urandom;
      bus.opdata2_i = $urandom;
      bus.annul_i   = i[0];
      @(posedge clk); #1;
      chk("end_hold_ready", 64'(bus.ready_o), 64'd1);
      chk("end_hold_result", bus.result_o, e);
    end
    bus.annul_i = 1'b0;
    drop_start();

    // Signed sign combinations.
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 33, e);
    chk("m7_2_const", e, {32'hFFFFFFFF, 32'hFFFFFFFD});
    drop_start();
    run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 33, e);
    chk("7_m2_const", e, {32'h00000001, 32'hFFFFFFFD});
    drop_start();

    // Divide by zero, both signedness.
    run_div(1'b0, 32'h1234, 32'h0, 2, e);
    drop_start();
    run_div(1'b1, 32'h1234, 32'h0, 2, e);
    drop_start();

    // Most-negative / -1, then async reset while in END clears outputs at once.
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 33, e);
    chk("minneg_const", e, {32'h00000000, 32'h80000000});
    #3 resetn = 1'b0;
    #1;
    chk("rst_end_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_end_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // start and annul together in FREE: stays idle; then a normal divide.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    watch_idle("start_annul_free", 3);
    run_div(1'b0, 32'd1000, 32'd3, 33, e);
    drop_start();

    // Annul at the tenth ON edge.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd5555;
    bus.opdata2_i    = 32'd11;
    bus.start_i      = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    watch_idle("annul_no_ready", 40);
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, 33, e);
    chk("ffff_10_const", e, {32'h0000000F, 32'h0FFFFFFF});
    drop_start();

    // Async reset between edges mid-ON.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd12345;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (6) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("rst_on_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_on_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    watch_idle("rst_no_ready", 40);
    run_div(1'b0, 32'd9, 32'd3, 33, e);
    chk("9_3_const", e, {32'd0, 32'd3});
    drop_start();

    // A handful of random divides in both modes.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> (i * 5);
      if (rb == 32'd0) rb = 32'd1;
      run_div(i[0], ra, rb, 33, e);
      drop_start();
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring integer divider.
- It is the responder side of the EX stage's start/ready divide handshake and serves DIV and DIVU.
- EX holds start_i high and stalls the pipeline while ready_o is low. EX drops start_i in the cycle it sees ready_o.
- result_o packs {remainder, quotient}. EX routes these to HI and LO respectively.

Parameters:
- WIDTH, 32, operand width. result_o is 2*WIDTH bits; the iteration count is WIDTH.

Ports:
- clk  input  1  system clock, rising-edge
- resetn  input  1  asynchronous, active-low reset
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at the start edge only
- opdata1_i  input  WIDTH  dividend; sampled at the start edge only
- opdata2_i  input  WIDTH  divisor; sampled at the start edge only
- start_i  input  1  request; level-held by the initiator until ready_o is seen
- annul_i  input  1  abort the in-flight divide
- result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; registered
- ready_o  output  1  result valid; registered

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=FREE, ready_o=0, result_o=0, counter=0, internal datapath registers=0.
  - Reset asserted mid-operation discards the operation. No ready_o is produced for it.
- States: FREE, BYZERO, ON, END. All outputs come from registers; there is no combinational path from inputs to outputs.
- FREE:
  - start_i=1 and annul_i=0 and opdata2_i==0 -> BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0 -> ON. At this edge:
    - latch the operand magnitudes (two's-complement negate negative operands when signed_div_i=1);
    - latch the sign flags: quotient sign = sign1 XOR sign2, remainder sign = sign1;
    - clear the partial remainder (WIDTH+1 bits) and set counter=0.
  - Otherwise stay in FREE. ready_o=0, result_o=0.
- BYZERO:
  - annul_i=1 -> FREE.
  - Else -> END with result_o=0.
- ON:
  - annul_i=1 -> FREE. ready_o stays 0 and the partial result is discarded.
  - Else perform one restoring step per edge:
    - shift {partial remainder, dividend} left by 1;
    - trial-subtract the divisor magnitude;
    - if non-negative, keep the difference and shift in quotient bit 1, else restore and shift in 0;
    - counter++.
  - On the step where counter==WIDTH-1, the step completes and the state goes to END.
  - At that edge result_o is loaded with the sign-corrected remainder and quotient (negate each when its sign flag is set and the divider is signed).
- END:
  - ready_o=1 and result_o is held stable. annul_i is ignored.
  - start_i=0 -> FREE on the next edge, with ready_o=0 and result_o=0.
  - start_i=1 -> stay in END. ready_o stays 1 and result_o stays stable; a new divide is not started until the FREE transition.
- Latency:
  - Counting the edge that samples start_i in FREE as edge 1, ready_o is high immediately after edge WIDTH+1 (33).
  - For divide-by-zero, ready_o is high after edge 2.
- Arithmetic rules:
  - Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0. There is no trap.
  - Magnitudes use WIDTH-bit unsigned arithmetic; the partial remainder is WIDTH+1 bits.
  - The remainder sign follows the dividend; the quotient truncates toward zero.
- Operand changes after the start edge have no effect.
- start_i and annul_i asserted together in FREE: annul wins and the state stays FREE.

Test Plan:
- Unsigned 100 / 7, start held high -> ready_o rises after edge 33, result_o = {32'd2, 32'd14}; dropping start_i -> next edge ready_o=0, result_o=0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- Divide by zero (0x1234 / 0), either signedness -> ready_o high after edge 2, result_o = 0. Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- annul_i pulsed at edge 10 of ON -> FREE next edge, ready_o never rises. A following 0xFFFFFFFF / 0x10 unsigned -> {0x0000000F, 0x0FFFFFFF} after 33 edges.
- start_i held in END for 5 cycles with changing operands -> ready_o stays 1 and result_o is unchanged. Toggling annul_i in END has no effect.
- resetn asserted asynchronously mid-ON (between edges) -> ready_o=0 and result_o=0 immediately. After release, a new 9 / 3 unsigned -> {0, 3} at edge 33.
